sdcmd_resp: RTL

//  Card-side responder for the SD CMD line, used for SD-card emulation and loopback test of the host controller.

---
 rtl/sdcmd_resp_if.sv | 29 ++
 rtl/sdcmd_resp.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sdcmd_resp_if.sv
// SD CMD responder bus: host-side line signals plus the user command/response handshake.
interface sdcmd_resp_if;
  logic        sdclk;
  logic        sdcmd_in;
  logic        sdcmd_out;
  logic        sdcmd_oe;
  logic        busy;
  logic        cmd_valid;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        crc_err;
  logic        resp_start;
  logic [5:0]  resp_cmd;
  logic [31:0] resp_arg;
  logic        resp_done;
  logic        resp_timeout;

  // Responder side.
  modport slave (
    input  sdclk, sdcmd_in, resp_start, resp_cmd, resp_arg,
    output sdcmd_out, sdcmd_oe, busy, cmd_valid, cmd, arg, crc_err, resp_done, resp_timeout
  );

  // Host model / user logic side.
  modport master (
    output sdclk, sdcmd_in, resp_start, resp_cmd, resp_arg,
    input  sdcmd_out, sdcmd_oe, busy, cmd_valid, cmd, arg, crc_err, resp_done, resp_timeout
  );
endinterface

// File: rtl/sdcmd_resp.sv
// Card-side SD CMD responder: oversamples sdclk/sdcmd, deframes 48-bit commands,
// hands cmd/arg to user logic and serialises a 48-bit response with CRC7.
// Optional feature macro: SDCMD_RESP_CRC_CHECK_EN (drop frames with a bad CRC7).
module sdcmd_resp #(
  parameter int NCR_CYCLES   = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input logic        clk,
  input logic        rstn,
  sdcmd_resp_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RX    = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_NCR   = 3'd4;
  localparam logic [2:0] S_TX    = 3'd5;
  localparam logic [2:0] S_END   = 3'd6;

  localparam logic [7:0] TMO_LAST = 8'(RESP_TIMEOUT - 1);
  localparam logic [6:0] NCR_LAST = 7'(NCR_CYCLES - 1);

  function automatic logic [6:0] f_crc7(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  logic [1:0]  r_sclk_s, r_cmd_s;
  logic        r_sclk_d;
  logic        w_rise, w_fall, w_cmd, w_crc_bad;
  logic [2:0]  r_state;
  logic [5:0]  r_bcnt;
  logic [46:0] r_sh;
  logic [6:0]  r_crc;
  logic [7:0]  r_tcnt;
  logic [6:0]  r_ncnt;
  logic [38:0] r_rsp;
  logic        r_out, r_oe, r_busy, r_cv, r_cerr, r_done, r_tmo;
  logic [5:0]  r_cmd;
  logic [31:0] r_arg;

  assign w_rise    = r_sclk_s[1] & ~r_sclk_d;
  assign w_fall    = ~r_sclk_s[1] & r_sclk_d;
  assign w_cmd     = r_cmd_s[1];
  assign w_crc_bad = (r_sh[7:1] != r_crc);

  // Two-flop synchronisers for the host clock and CMD line; idle-high reset avoids a false start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sclk_s <= 2'b11;
      r_cmd_s  <= 2'b11;
      r_sclk_d <= 1'b1;
    end else begin
      r_sclk_s <= {r_sclk_s[0], bus.sdclk};
      r_cmd_s  <= {r_cmd_s[0], bus.sdcmd_in};
      r_sclk_d <= r_sclk_s[1];
    end
  end

  // Receive / wait / respond state machine; samples on sdclk rise, drives on sdclk fall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_sh    <= '0;
      r_crc   <= '0;
      r_tcnt  <= '0;
      r_ncnt  <= '0;
      r_rsp   <= '0;
      r_out   <= 1'b1;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_cv    <= 1'b0;
      r_cerr  <= 1'b0;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
      r_cmd   <= '0;
      r_arg   <= '0;
    end else begin
      r_cv   <= 1'b0;
      r_cerr <= 1'b0;
      r_done <= 1'b0;
      r_tmo  <= 1'b0;
      case (r_state)
        S_IDLE: if (w_rise && !w_cmd) begin
          // Start bit is a 0 into a zero CRC, so the CRC stays at its init value.
          r_state <= S_RX;
          r_busy  <= 1'b1;
          r_bcnt  <= 6'd46;
          r_crc   <= '0;
        end
        S_RX: if (w_rise) begin
          r_sh <= {r_sh[45:0], w_cmd};
          if (r_bcnt >= 6'd8) r_crc <= f_crc7(r_crc, w_cmd);
          if (r_bcnt == 6'd0) r_state <= S_CHECK;
          else                r_bcnt  <= r_bcnt - 6'd1;
        end
        S_CHECK: begin
          r_tcnt <= '0;
          r_ncnt <= '0;
          if (!r_sh[46] || !r_sh[0]) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
`ifdef SDCMD_RESP_CRC_CHECK_EN
          else if (w_crc_bad) begin
            r_cerr  <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
`endif
          else begin
            r_cv    <= 1'b1;
            r_cerr  <= w_crc_bad;
            r_cmd   <= r_sh[45:40];
            r_arg   <= r_sh[39:8];
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Falls seen while waiting still count toward the Ncr window.
          if (w_fall && r_ncnt != 7'h7f) r_ncnt <= r_ncnt + 7'd1;
          if (bus.resp_start) begin
            r_rsp   <= {1'b0, bus.resp_cmd, bus.resp_arg};
            r_state <= S_NCR;
          end else if (w_rise) begin
            if (r_tcnt == TMO_LAST) begin
              r_tmo   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_tcnt <= r_tcnt + 8'd1;
            end
          end
        end
        S_NCR: if (w_fall) begin
          // A late reply satisfies this immediately and starts on the next fall.
          if (r_ncnt >= NCR_LAST) begin
            r_oe    <= 1'b1;
            r_out   <= 1'b0;
            r_bcnt  <= 6'd46;
            r_crc   <= '0;
            r_state <= S_TX;
          end else begin
            r_ncnt <= r_ncnt + 7'd1;
          end
        end
        S_TX: if (w_fall) begin
          if (r_bcnt >= 6'd8) begin
            r_out  <= r_rsp[38];
            r_crc  <= f_crc7(r_crc, r_rsp[38]);
            r_rsp  <= {r_rsp[37:0], 1'b0};
            r_bcnt <= r_bcnt - 6'd1;
          end else if (r_bcnt != 6'd0) begin
            r_out  <= r_crc[6];
            r_crc  <= {r_crc[5:0], 1'b0};
            r_bcnt <= r_bcnt - 6'd1;
          end else begin
            r_out   <= 1'b1;
            r_state <= S_END;
          end
        end
        S_END: if (w_fall) begin
          r_oe    <= 1'b0;
          r_out   <= 1'b1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sdcmd_out    = r_out;
  assign bus.sdcmd_oe     = r_oe;
  assign bus.busy         = r_busy;
  assign bus.cmd_valid    = r_cv;
  assign bus.cmd          = r_cmd;
  assign bus.arg          = r_arg;
  assign bus.crc_err      = r_cerr;
  assign bus.resp_done    = r_done;
  assign bus.resp_timeout = r_tmo;
endmodule
